// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Optional statistics counters are enabled with MIPS_FETCH_STATS_EN.
package mips_fetch_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          QENTRY_W         = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched {instr, pc4} entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [QENTRY_W-1:0] push_data,
    output logic [CW-1:0]       count,
    output logic [QENTRY_W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [QENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack, prefetch queue and IF/ID register.
// Define MIPS_FETCH_STATS_EN to add the bubble_cnt / flush_cnt counters.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         hold,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         id_valid,
    output logic [31:0]  id_instr,
    output logic [31:0]  id_pc4,
    output fetch_state_e dbg_state
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0]  bubble_cnt,
    output logic [31:0]  flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         started_q, started_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc4_q, id_pc4_d;

    logic [CW-1:0] q_count;
    qentry_t       q_head, q_in;
    logic          ack_v, pending, bypass, q_push, q_pop;

    // Handshake: imem_req/imem_addr stay stable until a cycle with imem_ack=1;
    // that cycle completes the transfer, and ack while req=0 is ignored.
    always_comb begin
        imem_req = started_q && ((state_q == ST_DISCARD) || (q_count < CW'(QDEPTH)));
        ack_v    = imem_ack && imem_req;
        pending  = imem_req && !imem_ack;
        bypass   = ack_v && (state_q == ST_RUN) && !redirect && !hold && (q_count == '0);
        q_push   = ack_v && (state_q == ST_RUN) && !redirect && !bypass;
        q_pop    = !redirect && !hold && (q_count != '0);
        q_in     = '{instr: imem_rdata, pc4: pc_q + 32'd4};
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect),
        .push_data (q_in),
        .count     (q_count),
        .head      (q_head)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        started_d  = 1'b1;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;

        // A redirect that catches a request in flight must wait for its ack.
        if (redirect) begin
            if (pending) begin
                state_d = ST_DISCARD;
                tgt_d   = redirect_pc;
            end else begin
                state_d = ST_RUN;
                pc_d    = redirect_pc;
            end
        end else if (state_q == ST_DISCARD) begin
            if (ack_v) begin
                state_d = ST_RUN;
                pc_d    = tgt_q;
            end
        end else if (ack_v) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!hold) begin
            if (q_pop) begin
                id_valid_d = 1'b1;
                id_instr_d = q_head.instr;
                id_pc4_d   = q_head.pc4;
            end else if (bypass) begin
                id_valid_d = 1'b1;
                id_instr_d = q_in.instr;
                id_pc4_d   = q_in.pc4;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            started_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            started_q  <= started_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;
    assign dbg_state = state_q;

`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        bubble_ev;

    always_comb begin
        bubble_ev    = !redirect && !hold && !q_pop && !bypass;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_ev && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (redirect && (flush_cnt_q != '1))   flush_cnt_d  = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: a queue-based reference model of the
// fetch stage plus a variable-latency instruction memory driver.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req, imem_ack;
    logic [31:0]  imem_addr, imem_rdata;
    logic         hold, redirect;
    logic [31:0]  redirect_pc;
    logic         id_valid;
    logic [31:0]  id_instr, id_pc4;
    fetch_state_e dbg_state;
`ifdef MIPS_FETCH_STATS_EN
    logic [31:0]  bubble_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [63:0] exp_q[$];
    logic [31:0] m_pc, m_tgt, m_instr, m_pc4, m_bub, m_flush;
    logic        m_valid, m_disc, m_started;

    // memory driver state
    logic ack_tied;
    int   lat_min, lat_max, mem_left;
    logic mem_busy;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .dbg_state   (dbg_state)
`ifdef MIPS_FETCH_STATS_EN
        ,
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic exp_req();
        return m_started && (m_disc || (exp_q.size() < QDEPTH));
    endfunction

    function automatic logic [98:0] dut_vec();
        return {(dbg_state == ST_DISCARD), imem_req, imem_addr, id_valid, id_instr, id_pc4};
    endfunction

    function automatic logic [98:0] exp_vec();
        return {m_disc, exp_req(), m_pc, m_valid, m_instr, m_pc4};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc      = RESET_PC;
        m_tgt     = RESET_PC;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_disc    = 1'b0;
        m_started = 1'b0;
        m_bub     = 32'h0;
        m_flush   = 32'h0;
        mem_busy  = 1'b0;
        mem_left  = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic        req, ackv, pend, loaded;
        logic [63:0] e;
        req    = exp_req();
        ackv   = imem_ack && req;
        pend   = req && !imem_ack;
        loaded = 1'b0;
        if (redirect) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
        end else begin
            if (!hold) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    m_instr = e[63:32];
                    m_pc4   = e[31:0];
                    m_valid = 1'b1;
                end else if (ackv && !m_disc) begin
                    m_instr = imem_rdata;
                    m_pc4   = m_pc + 32'd4;
                    m_valid = 1'b1;
                    loaded  = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_instr = 32'h0;
                    if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
                end
            end
            if (ackv && !m_disc && !loaded) exp_q.push_back({imem_rdata, m_pc + 32'd4});
        end
        if (redirect) begin
            if (pend) begin
                m_disc = 1'b1;
                m_tgt  = redirect_pc;
            end else begin
                m_disc = 1'b0;
                m_pc   = redirect_pc;
            end
        end else if (m_disc) begin
            if (ackv) begin
                m_disc = 1'b0;
                m_pc   = m_tgt;
            end
        end else if (ackv) begin
            m_pc = m_pc + 32'd4;
        end
        m_started = 1'b1;
    endtask

    // Drive one cycle of inputs at a negedge, step the model, wait for the next negedge.
    task automatic cycle(input logic h, input logic r, input logic [31:0] rpc);
        hold        = h;
        redirect    = r;
        redirect_pc = rpc;
        if (ack_tied) begin
            imem_ack   = 1'b1;
            imem_rdata = rom(imem_addr);
        end else if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = $urandom_range(lat_max, lat_min);
            end
            if (mem_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = rom(imem_addr);
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_left   = mem_left - 1;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        hold     = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== {1'b0, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_values: got %h exp %h", dut_vec(), {1'b0, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0});
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_zero_wait();
        ack_tied = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL zero_wait_model cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
            if (i == 0 && id_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_wait_first_bubble: got valid=%b exp 0", id_valid);
            end else if (i > 0 && {id_valid, id_instr, id_pc4} !== {1'b1, rom(32'(4 * (i - 1))), 32'(4 * i)}) begin
                n_bad++;
                $display("FAIL zero_wait_seq cyc%0d: got v=%b i=%h p=%h exp pc4=%h", i, id_valid, id_instr, id_pc4, 32'(4 * i));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] s_instr, s_pc4;
        s_instr = id_instr;
        s_pc4   = id_pc4;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec() || {id_valid, id_instr, id_pc4} !== {1'b1, s_instr, s_pc4}) begin
                n_bad++;
                $display("FAIL hold_frozen cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_req_drop: got req=%b exp 0", imem_req);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec() || {id_valid, id_pc4} !== {1'b1, s_pc4 + 32'(4 * (i + 1))}) begin
                n_bad++;
                $display("FAIL hold_drain cyc%0d: got v=%b p=%h exp p=%h", i, id_valid, id_pc4, s_pc4 + 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_slow_ack();
        logic [31:0] a, next_pc4;
        logic        r;
        ack_tied = 1'b0;
        lat_min  = 3;
        lat_max  = 3;
        do_reset();
        next_pc4 = 32'd4;
        for (int i = 0; i < 40; i++) begin
            a = imem_addr;
            r = imem_req;
            cycle(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL slow_model cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
            if (r && !imem_ack && imem_addr !== a) begin
                n_bad++;
                $display("FAIL slow_addr_stable cyc%0d: got %h exp %h", i, imem_addr, a);
            end else if (!id_valid && id_instr !== 32'h0) begin
                n_bad++;
                $display("FAIL slow_bubble_nop cyc%0d: got %h exp 0", i, id_instr);
            end else if (id_valid && {id_instr, id_pc4} !== {rom(next_pc4 - 32'd4), next_pc4}) begin
                n_bad++;
                $display("FAIL slow_seq cyc%0d: got p=%h exp p=%h", i, id_pc4, next_pc4);
            end
            if (id_valid) next_pc4 = next_pc4 + 32'd4;
        end
    endtask

    task automatic test_redirect_pending();
        logic found, moved;
        ack_tied = 1'b0;
        lat_min  = 2;
        lat_max  = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req && imem_addr == 32'h10 && !mem_busy) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL redir_wait_0x10: got addr=%h exp 00000010 within 60 cycles", imem_addr);
        end
        cycle(1'b0, 1'b1, 32'h40);
        n_cmp++;
        if ({(dbg_state == ST_DISCARD), imem_req, imem_addr, id_valid} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
            n_bad++;
            $display("FAIL redir_discard: got st=%0d req=%b addr=%h v=%b", dbg_state, imem_req, imem_addr, id_valid);
        end
        moved = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec() || id_instr === rom(32'h10)) begin
                n_bad++;
                $display("FAIL redir_model cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (!moved && imem_addr !== 32'h10) begin
                moved = 1'b1;
                n_cmp++;
                if (imem_addr !== 32'h40) begin
                    n_bad++;
                    $display("FAIL redir_next_addr: got %h exp 00000040", imem_addr);
                end
            end
        end
        n_cmp++;
        if (!moved) begin
            n_bad++;
            $display("FAIL redir_stuck: got addr=%h exp 00000040", imem_addr);
        end
    endtask

    task automatic test_redirect_ack_hold();
        ack_tied = 1'b1;
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h80);
        n_cmp++;
        if ({(dbg_state == ST_DISCARD), imem_req, imem_addr, id_valid, id_instr} !== {1'b0, 1'b1, 32'h80, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL redir_ack_hold: got %h exp %h", dut_vec(), exp_vec());
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({id_valid, id_instr, id_pc4} !== {1'b1, rom(32'h80), 32'h84} || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL redir_ack_first: got v=%b i=%h p=%h exp p=00000084", id_valid, id_instr, id_pc4);
        end
    endtask

    task automatic test_wrap();
        ack_tied = 1'b1;
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({id_valid, id_instr, id_pc4, imem_addr} !== {1'b1, rom(32'hFFFF_FFFC), 32'h0, 32'h0} || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL pc_wrap: got p=%h addr=%h exp p=00000000 addr=00000000", id_pc4, imem_addr);
        end
    endtask

    task automatic test_reset_mid_discard();
        ack_tied = 1'b0;
        lat_min  = 3;
        lat_max  = 3;
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h200);
        n_cmp++;
        if (dbg_state !== ST_DISCARD) begin
            n_bad++;
            $display("FAIL rst_mid_enter_discard: got st=%0d exp 1", dbg_state);
        end
        redirect = 1'b0;
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== {1'b0, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %h exp %h", dut_vec(), {1'b0, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0});
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            n_bad++;
            $display("FAIL rst_mid_first_fetch: got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rst_mid_model cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic        h, r;
        logic [31:0] rpc;
        ack_tied = 1'b0;
        lat_min  = 0;
        lat_max  = 3;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) ack_tied = ($urandom_range(3, 0) == 0);
            h   = ($urandom_range(99, 0) < 30);
            r   = ($urandom_range(99, 0) < 8);
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
            cycle(h, r, rpc);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_model cyc%0d: got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
`ifdef MIPS_FETCH_STATS_EN
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== {m_bub, m_flush}) begin
            n_bad++;
            $display("FAIL stats_counts: got bub=%0d fl=%0d exp bub=%0d fl=%0d", bubble_cnt, flush_cnt, m_bub, m_flush);
        end
`endif
    endtask

    initial begin
        reset       = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        ack_tied    = 1'b0;
        lat_min     = 0;
        lat_max     = 0;
        model_reset();
        test_reset();
        test_zero_wait();
        test_hold();
        test_slow_ack();
        test_redirect_pending();
        test_redirect_ack_hold();
        test_wrap();
        test_reset_mid_discard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
